// File: rtl/roce_stack_pkg.sv
// -----------------------------------------------------------------------------
// roce_stack_pkg
// Shared types for the RoCE stack address translation path.
//   dma_req_t    : translated DMA request {paddr, buflen, accesdesc}; the RoCE
//                  request handler uses the same type.
//   xlat_entry_t : one per-QP region table entry, also the config write payload.
//   xlat_state_e : translator FSM states.
// -----------------------------------------------------------------------------
package roce_stack_pkg;

  localparam int VADDR_W  = 64;
  localparam int PADDR_W  = 64;
  localparam int BUFLEN_W = 48;
  localparam int QPN_W    = 16;
  localparam int ACC_W    = 4;

  typedef struct packed {
    logic [PADDR_W-1:0]  paddr;
    logic [BUFLEN_W-1:0] buflen;
    logic [ACC_W-1:0]    accesdesc;
  } dma_req_t;

  typedef struct packed {
    logic                vld;
    logic [QPN_W-1:0]    qpn;
    logic [VADDR_W-1:0]  vbase;
    logic [PADDR_W-1:0]  pbase;
    logic [BUFLEN_W-1:0] buflen;
    logic [ACC_W-1:0]    accesdesc;
  } xlat_entry_t;

  typedef enum logic [1:0] {
    XL_IDLE   = 2'd0,
    XL_LOOKUP = 2'd1,
    XL_CHECK  = 2'd2,
    XL_RESP   = 2'd3
  } xlat_state_e;

endpackage : roce_stack_pkg

// File: rtl/roce_stack_addr_translator_if.sv
// -----------------------------------------------------------------------------
// roce_stack_addr_translator_if
// Bundles the translator's three handshakes:
//   req_addr_*  : lookup request (vaddr, qpn) from the RoCE request handler
//   resp_addr_* : translation response (dma_req_t + miss flag)
//   cfg_wr_*    : region table write port
// Modports:
//   master : the requester / table programmer side
//   slave  : the translator side
// -----------------------------------------------------------------------------
interface roce_stack_addr_translator_if;
  import roce_stack_pkg::*;

  logic               req_addr_valid;
  logic               req_addr_ready;
  logic [VADDR_W-1:0] req_addr_vaddr;
  logic [QPN_W-1:0]   req_addr_qpn;

  logic               resp_addr_valid;
  logic               resp_addr_ready;
  dma_req_t           resp_addr_data;
  logic               resp_addr_miss;

  logic               cfg_wr_valid;
  logic               cfg_wr_ready;
  xlat_entry_t        cfg_wr_entry;

  modport master (
    output req_addr_valid, req_addr_vaddr, req_addr_qpn,
    output resp_addr_ready,
    output cfg_wr_valid, cfg_wr_entry,
    input  req_addr_ready,
    input  resp_addr_valid, resp_addr_data, resp_addr_miss,
    input  cfg_wr_ready
  );

  modport slave (
    input  req_addr_valid, req_addr_vaddr, req_addr_qpn,
    input  resp_addr_ready,
    input  cfg_wr_valid, cfg_wr_entry,
    output req_addr_ready,
    output resp_addr_valid, resp_addr_data, resp_addr_miss,
    output cfg_wr_ready
  );

endinterface : roce_stack_addr_translator_if

// File: rtl/roce_stack_xlat_table.sv
// -----------------------------------------------------------------------------
// roce_stack_xlat_table
// N_ENTRIES x xlat_entry_t register array with one write port and one
// synchronous read port. The whole array is cleared by arst_i so that every
// entry comes out of reset invalid.
// Ports:
//   clk_i, arst_i      : clock, asynchronous active-high reset
//   wr_en/wr_idx/wr_entry : write port, takes effect at the clock edge
//   rd_en/rd_idx       : read request; rd_entry holds the registered result
// -----------------------------------------------------------------------------
module roce_stack_xlat_table
  import roce_stack_pkg::*;
#(
  parameter int N_ENTRIES = 16
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         wr_en,
  input  logic [$clog2(N_ENTRIES)-1:0] wr_idx,
  input  xlat_entry_t                  wr_entry,
  input  logic                         rd_en,
  input  logic [$clog2(N_ENTRIES)-1:0] rd_idx,
  output xlat_entry_t                  rd_entry
);

  xlat_entry_t mem [N_ENTRIES];

  // NOTE: this array is deliberately reset: an entry must read vld=0 after
  // reset, so it cannot be mapped onto an unresettable RAM macro.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        mem[i] <= '0;
      end
      rd_entry <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_entry;
      end
      if (rd_en) begin
        rd_entry <= mem[rd_idx];
      end
    end
  end

endmodule : roce_stack_xlat_table

// File: rtl/roce_stack_addr_translator.sv
// -----------------------------------------------------------------------------
// roce_stack_addr_translator
// Responder side of the vaddr->paddr lookup handshake. A request (vaddr, qpn)
// indexes a per-QP region table with qpn's low bits; the entry is checked for
// tag and bounds and a dma_req_t {paddr, remaining buflen, accesdesc} or a miss
// is returned. One request is in flight at a time.
// Ports:
//   clk_i, arst_i  : clock, asynchronous active-high reset
//   xl (slave)     : request / response / config-write handshakes
//   stat_hit_o     : saturating count of hit responses handed over
//   stat_miss_o    : saturating count of miss responses handed over
// Timing: request accepted in cycle 0, table read in cycle 1 (XL_LOOKUP),
// check in cycle 2 (XL_CHECK), response valid from cycle 3 (XL_RESP).
// -----------------------------------------------------------------------------
module roce_stack_addr_translator
  import roce_stack_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int CNT_W     = 32
) (
  input  logic                           clk_i,
  input  logic                           arst_i,
  roce_stack_addr_translator_if.slave    xl,
  output logic [CNT_W-1:0]               stat_hit_o,
  output logic [CNT_W-1:0]               stat_miss_o
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  xlat_state_e        state;
  logic [VADDR_W-1:0] vaddr_q;
  logic [QPN_W-1:0]   qpn_q;
  xlat_entry_t        entry_q;

  logic               req_ready_q;
  logic               cfg_ready_q;
  logic               resp_valid_q;
  dma_req_t           resp_data_q;
  logic               resp_miss_q;

  logic               tbl_wr_en;
  logic               tbl_rd_en;

  assign xl.req_addr_ready  = req_ready_q;
  assign xl.cfg_wr_ready    = cfg_ready_q;
  assign xl.resp_addr_valid = resp_valid_q;
  assign xl.resp_addr_data  = resp_data_q;
  assign xl.resp_addr_miss  = resp_miss_q;

  // Config writes are only refused during the table read cycle, so a write
  // accepted together with a request accept lands before that request's read.
  assign tbl_wr_en = xl.cfg_wr_valid && cfg_ready_q;
  assign tbl_rd_en = (state == XL_LOOKUP);

  // The registered read output is the snapshot the check works from; later
  // writes cannot disturb an in-flight response.
  roce_stack_xlat_table #(
    .N_ENTRIES (N_ENTRIES)
  ) u_table (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .wr_en    (tbl_wr_en),
    .wr_idx   (xl.cfg_wr_entry.qpn[IDX_W-1:0]),
    .wr_entry (xl.cfg_wr_entry),
    .rd_en    (tbl_rd_en),
    .rd_idx   (qpn_q[IDX_W-1:0]),
    .rd_entry (entry_q)
  );

  // ---------------------------------------------------------------------------
  // Tag and bounds check on the snapshotted entry.
  // ---------------------------------------------------------------------------
  logic [VADDR_W-1:0] off;
  logic               hit;
  dma_req_t           hit_data;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    off      = '0;
    hit      = 1'b0;
    hit_data = '0;

    off = vaddr_q - entry_q.vbase;
    // A zero-length region fails the off < buflen test, so it always misses.
    hit = entry_q.vld
       && (entry_q.qpn == qpn_q)
       && (vaddr_q >= entry_q.vbase)
       && (off < {{(VADDR_W-BUFLEN_W){1'b0}}, entry_q.buflen});

    hit_data.paddr     = entry_q.pbase + off;
    hit_data.buflen    = entry_q.buflen - off[BUFLEN_W-1:0];
    hit_data.accesdesc = entry_q.accesdesc;
  end

  // ---------------------------------------------------------------------------
  // FSM with registered handshake outputs and saturating statistics.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= XL_IDLE;
      vaddr_q      <= '0;
      qpn_q        <= '0;
      req_ready_q  <= 1'b1;
      cfg_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_miss_q  <= 1'b0;
      stat_hit_o   <= '0;
      stat_miss_o  <= '0;
    end else begin
      case (state)
        XL_IDLE: begin
          if (xl.req_addr_valid && req_ready_q) begin
            vaddr_q     <= xl.req_addr_vaddr;
            qpn_q       <= xl.req_addr_qpn;
            req_ready_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            state       <= XL_LOOKUP;
          end
        end

        XL_LOOKUP: begin
          cfg_ready_q <= 1'b1;
          state       <= XL_CHECK;
        end

        XL_CHECK: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= hit ? hit_data : '0;
          resp_miss_q  <= !hit;
          state        <= XL_RESP;
        end

        XL_RESP: begin
          if (xl.resp_addr_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= XL_IDLE;
            if (resp_miss_q) begin
              if (stat_miss_o != '1) stat_miss_o <= stat_miss_o + CNT_W'(1);
            end else begin
              if (stat_hit_o != '1) stat_hit_o <= stat_hit_o + CNT_W'(1);
            end
          end
        end

        default: state <= XL_IDLE;
      endcase
    end
  end

endmodule : roce_stack_addr_translator

// File: tb/tb_roce_stack_addr_translator.sv
// -----------------------------------------------------------------------------
// tb_roce_stack_addr_translator
// Directed bench for roce_stack_addr_translator. Expected values are worked
// out by hand from the entry contents (off = vaddr - vbase,
// paddr = pbase + off, buflen = entry.buflen - off) and a hit/miss tally.
// -----------------------------------------------------------------------------
module tb_roce_stack_addr_translator;
  import roce_stack_pkg::*;

  localparam int CNT_W = 32;

  logic             clk  = 1'b0;
  logic             arst = 1'b0;
  logic [CNT_W-1:0] stat_hit;
  logic [CNT_W-1:0] stat_miss;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  roce_stack_addr_translator_if xl ();

  roce_stack_addr_translator #(
    .N_ENTRIES (16),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .xl          (xl),
    .stat_hit_o  (stat_hit),
    .stat_miss_o (stat_miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic xlat_entry_t mk_entry(input logic vld, input logic [15:0] qpn,
                                           input logic [63:0] vbase, input logic [63:0] pbase,
                                           input logic [47:0] buflen, input logic [3:0] acc);
    xlat_entry_t e;
    e.vld = vld; e.qpn = qpn; e.vbase = vbase; e.pbase = pbase;
    e.buflen = buflen; e.accesdesc = acc;
    return e;
  endfunction

  function automatic dma_req_t mk_dma(input logic [63:0] paddr, input logic [47:0] buflen,
                                      input logic [3:0] acc);
    dma_req_t d;
    d.paddr = paddr; d.buflen = buflen; d.accesdesc = acc;
    return d;
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "/stat_hit"},  stat_hit,  exp_hit);
    check({tag, "/stat_miss"}, stat_miss, exp_miss);
  endtask

  // Programs one table entry while the translator is idle.
  task automatic cfg_write(input xlat_entry_t e);
    int k;
    @(negedge clk);
    xl.cfg_wr_entry = e;
    xl.cfg_wr_valid = 1'b1;
    k = 0;
    while (!xl.cfg_wr_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("cfg_write/ready_seen", k < 10, 1'b1);
    @(negedge clk);
    xl.cfg_wr_valid = 1'b0;
  endtask

  // One full lookup. Optionally a config write is presented in the accept
  // cycle; resp_addr_ready_i is held low for `hold` cycles once valid.
  task automatic lookup(input string tag, input logic [63:0] va, input logic [15:0] qpn,
                        input bit with_cfg, input xlat_entry_t cfg, input int hold,
                        input logic exp_is_miss, input dma_req_t exp_data);
    int k;
    @(negedge clk);
    check({tag, "/req_ready"}, xl.req_addr_ready, 1'b1);
    xl.req_addr_vaddr = va;
    xl.req_addr_qpn   = qpn;
    xl.req_addr_valid = 1'b1;
    if (with_cfg) begin
      xl.cfg_wr_entry = cfg;
      xl.cfg_wr_valid = 1'b1;
    end
    // The negedge above is in cycle 0 (accept cycle); count cycles to valid.
    k = 0;
    do begin
      @(negedge clk);
      xl.cfg_wr_valid = 1'b0;
      k++;
    end while (!xl.resp_addr_valid && k < 20);
    check({tag, "/latency"}, k, 3);
    check({tag, "/miss"}, xl.resp_addr_miss, exp_is_miss);
    check({tag, "/data"}, xl.resp_addr_data, exp_data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, xl.resp_addr_valid, 1'b1);
      check({tag, "/hold_data"}, xl.resp_addr_data, exp_data);
      check({tag, "/hold_miss"}, xl.resp_addr_miss, exp_is_miss);
      check({tag, "/hold_req_ready"}, xl.req_addr_ready, 1'b0);
      check_stats({tag, "/hold"});
    end
    xl.resp_addr_ready = 1'b1;
    @(negedge clk);
    xl.resp_addr_ready = 1'b0;
    xl.req_addr_valid  = 1'b0;
    if (exp_is_miss) exp_miss++; else exp_hit++;
    check({tag, "/valid_after"}, xl.resp_addr_valid, 1'b0);
    check_stats(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    xlat_entry_t none;
    xlat_entry_t e3;
    xlat_entry_t e19;
    int k;
    none = '0;
    e3   = mk_entry(1'b1, 16'd3,  64'h1000, 64'h8000_0000, 48'h400, 4'h3);
    e19  = mk_entry(1'b1, 16'd19, 64'h2000, 64'h9000_0000, 48'h100, 4'h5);

    xl.req_addr_valid  = 1'b0;
    xl.req_addr_vaddr  = '0;
    xl.req_addr_qpn    = '0;
    xl.resp_addr_ready = 1'b0;
    xl.cfg_wr_valid    = 1'b0;
    xl.cfg_wr_entry    = '0;

    // Reset values.
    #3 arst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst/req_ready",  xl.req_addr_ready, 1'b1);
    check("rst/resp_valid", xl.resp_addr_valid, 1'b0);
    check("rst/resp_data",  xl.resp_addr_data, '0);
    check("rst/resp_miss",  xl.resp_addr_miss, 1'b0);
    check("rst/cfg_ready",  xl.cfg_wr_ready, 1'b1);
    check_stats("rst");
    arst = 1'b0;

    // Empty table: miss.
    lookup("empty", 64'h1000, 16'd3, 1'b0, none, 0, 1'b1, '0);

    // Program qpn 3 and check hit plus bounds.
    cfg_write(e3);
    lookup("hit_1100", 64'h1100, 16'd3, 1'b0, none, 0, 1'b0,
           mk_dma(64'h8000_0100, 48'h300, 4'h3));
    lookup("off_eq_len", 64'h1400, 16'd3, 1'b0, none, 0, 1'b1, '0);
    lookup("below_base", 64'h0FFF, 16'd3, 1'b0, none, 0, 1'b1, '0);
    lookup("last_byte", 64'h13FF, 16'd3, 1'b0, none, 0, 1'b0,
           mk_dma(64'h8000_03FF, 48'h1, 4'h3));

    // Backpressure: response held for 5 cycles, counter bumps once.
    lookup("hold5", 64'h1200, 16'd3, 1'b0, none, 5, 1'b0,
           mk_dma(64'h8000_0200, 48'h200, 4'h3));

    // Index aliasing: qpn 19 evicts qpn 3 (both index 3).
    cfg_write(e19);
    lookup("alias_q3", 64'h1100, 16'd3, 1'b0, none, 0, 1'b1, '0);
    lookup("alias_q19", 64'h2010, 16'd19, 1'b0, none, 0, 1'b0,
           mk_dma(64'h9000_0010, 48'hF0, 4'h5));

    // Config write during XL_LOOKUP stalls one cycle and does not alter the
    // in-flight response (it invalidates qpn 19).
    @(negedge clk);
    xl.req_addr_vaddr = 64'h2020;
    xl.req_addr_qpn   = 16'd19;
    xl.req_addr_valid = 1'b1;
    @(negedge clk);
    check("stall/cfg_ready_lookup", xl.cfg_wr_ready, 1'b0);
    check("stall/req_ready_lookup", xl.req_addr_ready, 1'b0);
    xl.cfg_wr_entry = mk_entry(1'b0, 16'd19, 64'h2000, 64'h9000_0000, 48'h100, 4'h5);
    xl.cfg_wr_valid = 1'b1;
    @(negedge clk);
    check("stall/cfg_ready_after", xl.cfg_wr_ready, 1'b1);
    @(negedge clk);
    xl.cfg_wr_valid = 1'b0;
    check("stall/resp_valid", xl.resp_addr_valid, 1'b1);
    check("stall/resp_miss", xl.resp_addr_miss, 1'b0);
    check("stall/resp_data", xl.resp_addr_data, mk_dma(64'h9000_0020, 48'hE0, 4'h5));
    xl.resp_addr_ready = 1'b1;
    @(negedge clk);
    xl.resp_addr_ready = 1'b0;
    xl.req_addr_valid  = 1'b0;
    exp_hit++;
    check_stats("stall");
    lookup("invalidated_q19", 64'h2020, 16'd19, 1'b0, none, 0, 1'b1, '0);

    // Write accepted in the same cycle as the request is visible to it.
    lookup("same_cycle_wr", 64'h8, 16'd5, 1'b1,
           mk_entry(1'b1, 16'd5, 64'h0, 64'h100, 48'h10, 4'h1), 0, 1'b0,
           mk_dma(64'h108, 48'h8, 4'h1));

    // Zero-length region always misses.
    cfg_write(mk_entry(1'b1, 16'd7, 64'h3000, 64'hA000_0000, 48'h0, 4'h2));
    lookup("zero_len", 64'h3000, 16'd7, 1'b0, none, 0, 1'b1, '0);

    // Reset while in XL_RESP: valid drops at once, table and counters clear.
    cfg_write(e3);
    @(negedge clk);
    xl.req_addr_vaddr = 64'h1100;
    xl.req_addr_qpn   = 16'd3;
    xl.req_addr_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!xl.resp_addr_valid && k < 20);
    check("arst/pre_valid", xl.resp_addr_valid, 1'b1);
    check("arst/pre_miss", xl.resp_addr_miss, 1'b0);
    arst = 1'b1;
    xl.req_addr_valid = 1'b0;
    #1;
    check("arst/valid_dropped", xl.resp_addr_valid, 1'b0);
    check("arst/req_ready", xl.req_addr_ready, 1'b1);
    exp_hit  = 0;
    exp_miss = 0;
    check_stats("arst");
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check_stats("arst_release");
    lookup("after_arst", 64'h1100, 16'd3, 1'b0, none, 0, 1'b1, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_roce_stack_addr_translator
